// File: rtl/pwm_pkg.sv
// Purpose : shared constants and types for the multi-channel PWM block.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

    // Counting mode, latched at each period boundary.
    localparam logic PWM_MODE_EDGE   = 1'b0;
    localparam logic PWM_MODE_CENTER = 1'b1;

    // Smallest period accepted; shorter requests are raised to this.
    localparam int unsigned PWM_MIN_PERIOD = 2;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_ch.sv
// Purpose : one PWM channel: compare counter against duty, apply polarity, register.
// Latency : 1 clock from counter value to o_pwm.
// Backpressure: none; free-running output.
//
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_en          counter running; when low the output parks at its idle level
//   i_cnt         shared period counter
//   i_duty        active duty for this channel
//   o_pwm         registered PWM output
module pwm_ch
    import pwm_pkg::*;
#(
    parameter int   CNT_W = 16,
    parameter logic INV   = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_duty,
    output logic             o_pwm
);

    // duty=0 never matches and duty>=period always matches, so both
    // extremes are constant levels without any special-casing.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            o_pwm <= INV;
        end else begin
            o_pwm <= (i_cnt < i_duty) ^ INV;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Purpose : multi-channel PWM with shared edge/center-aligned counter and shadowed period/duty.
// Latency : o_pwm 1 clock after the counter; shadow values apply from the first count of the next period.
// Backpressure: none; i_load is always accepted, a newer load overwrites a pending one.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_en              counter run enable (low: counter parked at 0, outputs idle)
//   i_mode            0 edge-aligned, 1 center-aligned; latched at period boundaries
//   i_load            capture i_period/i_duty into the shadow registers
//   i_period, i_duty  requested period and packed per-channel duties
//   o_pwm             registered PWM outputs
//   o_pending         shadow values waiting for the next boundary
//   o_period_start    high on the first count of each period
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int                NUM_CH     = 4,
    parameter int                CNT_W      = 16,
    parameter int                DEF_PERIOD = 1000,
    parameter logic [NUM_CH-1:0] INV_MASK   = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_mode,
    input  logic                    i_load,
    input  logic [CNT_W-1:0]        i_period,
    input  logic [NUM_CH*CNT_W-1:0] i_duty,
    output logic [NUM_CH-1:0]       o_pwm,
    output logic                    o_pending,
    output logic                    o_period_start
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(PWM_MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0]        cnt;
    pwm_dir_e                dir;
    logic                    mode;
    logic [CNT_W-1:0]        per_act;
    logic [CNT_W-1:0]        per_shd;
    logic [NUM_CH*CNT_W-1:0] duty_act;
    logic [NUM_CH*CNT_W-1:0] duty_shd;
    logic                    pending;

    logic at_top;
    logic wrap;
    logic xfer;

    assign at_top = (cnt >= per_act - ONE);

    // wrap marks the last count of a period: the counter returns to 0 on
    // the following edge. In center mode the down ramp ends at 1; with a
    // period of 2 the top is also 1, so there is no down ramp at all.
    always_comb begin
        wrap = 1'b0;
        if (i_en) begin
            if (dir == DIR_DOWN) begin
                wrap = (cnt <= ONE);
            end else if (at_top) begin
                wrap = (mode == PWM_MODE_EDGE) || (cnt <= ONE);
            end
        end
    end

    // While stopped there is no period to protect, so shadows move at once.
    assign xfer = pending && (!i_en || wrap);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt      <= '0;
            dir      <= DIR_UP;
            mode     <= PWM_MODE_EDGE;
            per_act  <= DEF_P;
            per_shd  <= DEF_P;
            duty_act <= '0;
            duty_shd <= '0;
            pending  <= 1'b0;
        end else begin
            if (!i_en || wrap) begin
                cnt  <= '0;
                dir  <= DIR_UP;
                mode <= i_mode;
            end else if (dir == DIR_DOWN || at_top) begin
                // at_top without wrap only happens in center mode: turn around
                cnt <= cnt - ONE;
                dir <= DIR_DOWN;
            end else begin
                cnt <= cnt + ONE;
            end

            if (xfer) begin
                per_act  <= per_shd;
                duty_act <= duty_shd;
            end

            // A load on the boundary cycle lands after the transfer above has
            // taken the old shadow, so it stays pending for the next period.
            if (i_load) begin
                per_shd  <= (i_period < MIN_P) ? MIN_P : i_period;
                duty_shd <= i_duty;
                pending  <= 1'b1;
            end else if (xfer) begin
                pending <= 1'b0;
            end
        end
    end

    assign o_pending      = pending;
    assign o_period_start = !i_rst && i_en && (cnt == '0);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pwm_ch #(
            .CNT_W (CNT_W),
            .INV   (INV_MASK[k])
        ) u_ch (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_en   (i_en),
            .i_cnt  (cnt),
            .i_duty (duty_act[k*CNT_W +: CNT_W]),
            .o_pwm  (o_pwm[k])
        );
    end

endmodule
